// File: rtl/mul_acc.sv
// Dot-product back end: drains products from the iterative multiplier and sums a programmed count.
// Define MUL_ACC_SAT_EN to saturate acc_data on overflow instead of wrapping.
//
// state | meaning
// IDLE  | waiting for start
// WAIT  | waiting for mul_rd_ready
// REQ   | mul_rd_en pulse to multiplier
// CAP   | waiting for mul_rd_val, then add
// DONE  | acc_data valid until acc_rd_en
module mul_acc #(
    parameter int PROD_WIDTH = 64,
    parameter int ACC_WIDTH  = 72,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    input  logic                  mul_rd_ready,
    input  logic                  mul_rd_val,
    input  logic [PROD_WIDTH-1:0] mul_rd_data,
    output logic                  mul_rd_en,
    output logic [ACC_WIDTH-1:0]  acc_data,
    output logic                  acc_val,
    input  logic                  acc_rd_en,
    output logic                  overflow
);

    typedef enum logic [2:0] {IDLE, WAIT, REQ, CAP, DONE} state_t;

    state_t               state, state_next;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] count;
    logic [ACC_WIDTH:0]   sum;
    logic                 carry;
    logic                 last;

    assign sum   = {1'b0, acc_data} + (ACC_WIDTH+1)'(mul_rd_data);
    assign carry = sum[ACC_WIDTH];
    // Compared one bit wider so len = 2^LEN_WIDTH-1 never wraps.
    assign last  = ({1'b0, count} + (LEN_WIDTH+1)'(1)) == {1'b0, len_q};

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = (len == '0) ? DONE : WAIT;
            WAIT: if (mul_rd_ready) state_next = REQ;
            REQ:  state_next = CAP;
            CAP:  if (mul_rd_val) state_next = last ? DONE : WAIT;
            DONE: if (acc_rd_en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            len_q     <= '0;
            count     <= '0;
            acc_data  <= '0;
            overflow  <= 1'b0;
            mul_rd_en <= 1'b0;
            acc_val   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            mul_rd_en <= (state_next == REQ);
            acc_val   <= (state_next == DONE);
            busy      <= (state_next != IDLE);

            if (state == IDLE && start) begin
                len_q    <= len;
                count    <= '0;
                acc_data <= '0;
                overflow <= 1'b0;
            end

            if (state == CAP && mul_rd_val) begin
                count <= count + LEN_WIDTH'(1);
                if (carry) overflow <= 1'b1;
`ifdef MUL_ACC_SAT_EN
                // Once saturated, stay saturated for the rest of the run.
                if (carry || overflow) acc_data <= '1;
                else                   acc_data <= sum[ACC_WIDTH-1:0];
`else
                acc_data <= sum[ACC_WIDTH-1:0];
`endif
            end
        end
    end

endmodule

// File: tb/tb_mul_acc.sv
// Self-checking bench for mul_acc with a behavioural multiplier read-port model.
module tb_mul_acc;
    localparam int PW = 64;
    localparam int AW = 64;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic          busy;
    logic          mul_rd_ready = 1'b0;
    logic          mul_rd_val = 1'b0;
    logic [PW-1:0] mul_rd_data = '0;
    logic          mul_rd_en;
    logic [AW-1:0] acc_data;
    logic          acc_val;
    logic          acc_rd_en = 1'b0;
    logic          overflow;

    mul_acc #(.PROD_WIDTH(PW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy),
        .mul_rd_ready(mul_rd_ready), .mul_rd_val(mul_rd_val), .mul_rd_data(mul_rd_data),
        .mul_rd_en(mul_rd_en), .acc_data(acc_data), .acc_val(acc_val),
        .acc_rd_en(acc_rd_en), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Product store: main process writes, multiplier model reads.
    logic [PW-1:0] prod_mem [0:1023];
    int  wr_ptr = 0;
    int  rd_ptr = 0;
    bit  ready_gate = 1'b1;
    int  val_delay = 0;
    int  rd_en_cycles = 0;
    int  phase = 0;
    int  dcnt = 0;
    int  en_base = 0;

    // Multiplier read port: ready while a product is pending, one val pulse per rd_en.
    always @(negedge clk) begin
        if (mul_rd_en) rd_en_cycles++;
        if (reset) begin
            phase        = 0;
            mul_rd_val   = 1'b0;
            mul_rd_ready = 1'b0;
            rd_ptr       = wr_ptr;
        end else begin
            case (phase)
                0: if (mul_rd_en) begin
                    phase = 1;
                    dcnt = val_delay;
                    mul_rd_ready = 1'b0;
                end
                1: if (dcnt == 0) begin
                    mul_rd_val  = 1'b1;
                    mul_rd_data = prod_mem[rd_ptr % 1024];
                    rd_ptr++;
                    phase = 2;
                end else begin
                    dcnt--;
                end
                default: begin
                    mul_rd_val = 1'b0;
                    phase = 0;
                end
            endcase
            if (phase == 0) mul_rd_ready = ready_gate && (rd_ptr != wr_ptr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [PW-1:0] v);
        prod_mem[wr_ptr % 1024] = v;
        wr_ptr++;
    endtask

    task automatic start_run(input int n);
        en_base = rd_en_cycles;
        start = 1'b1;
        len = LW'(n);
        tick();
        start = 1'b0;
        if (n == 0) check("len0_done_next_cycle", acc_val, 1'b1);
    endtask

    task automatic wait_done(input bit poke);
        int k;
        for (k = 0; k < 3000 && !acc_val; k++) begin
            if (poke && k == 2) begin start = 1'b1; len = LW'(2); end
            if (poke && k == 5) start = 1'b0;
            tick();
        end
        start = 1'b0;
        if (!acc_val) check("done_timeout", 1'b0, 1'b1);
        if (poke) begin
            start = 1'b1;
            tick();
            tick();
            start = 1'b0;
            check("start_in_done_ignored", acc_val, 1'b1);
        end
    endtask

    task automatic finish_run(input string name, input int n,
                              input logic [AW-1:0] exp_data, input bit exp_ovf);
        check({name, "_acc_val"}, acc_val, 1'b1);
        check({name, "_acc_data"}, acc_data, exp_data);
        check({name, "_overflow"}, overflow, exp_ovf);
        check({name, "_rd_en_cycles"}, rd_en_cycles - en_base, n);
        acc_rd_en = 1'b1;
        tick();
        acc_rd_en = 1'b0;
        check({name, "_acc_val_cleared"}, acc_val, 1'b0);
        check({name, "_busy_cleared"}, busy, 1'b0);
        check({name, "_acc_data_held"}, acc_data, exp_data);
    endtask

    typedef struct {
        int            n;
        logic [PW-1:0] p [4];
        logic [AW-1:0] exp_data;
        bit            exp_ovf;
    } vec_t;

`ifdef MUL_ACC_SAT_EN
    localparam logic [AW-1:0] OVF_DATA = 64'hFFFF_FFFF_FFFF_FFFF;
`else
    localparam logic [AW-1:0] OVF_DATA = 64'd1;
`endif

    initial begin
        vec_t          tbl [5];
        logic [127:0]  total;
        logic [AW-1:0] exp_d;
        bit            exp_o;
        int            n;
        int            en_seen;
        logic [PW-1:0] p;

        tbl[0].n = 3; tbl[0].p = '{64'd5, 64'd7, 64'd11, 64'd0};
        tbl[0].exp_data = 64'd23; tbl[0].exp_ovf = 1'b0;
        tbl[1].n = 0; tbl[1].p = '{64'd0, 64'd0, 64'd0, 64'd0};
        tbl[1].exp_data = 64'd0; tbl[1].exp_ovf = 1'b0;
        tbl[2].n = 2; tbl[2].p = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 64'd0};
        tbl[2].exp_data = OVF_DATA; tbl[2].exp_ovf = 1'b1;
        tbl[3].n = 4; tbl[3].p = '{64'd1, 64'd2, 64'd3, 64'd4};
        tbl[3].exp_data = 64'd10; tbl[3].exp_ovf = 1'b0;
        tbl[4].n = 1; tbl[4].p = '{64'd9, 64'd0, 64'd0, 64'd0};
        tbl[4].exp_data = 64'd9; tbl[4].exp_ovf = 1'b0;

        tick();
        tick();
        check("rst_mul_rd_en", mul_rd_en, 1'b0);
        check("rst_acc_data", acc_data, 64'd0);
        check("rst_acc_val", acc_val, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            val_delay = i % 2;
            for (int j = 0; j < tbl[i].n; j++) push(tbl[i].p[j]);
            start_run(tbl[i].n);
            wait_done(i == 0);
            finish_run($sformatf("vec%0d", i), tbl[i].n, tbl[i].exp_data, tbl[i].exp_ovf);
        end

        // Ready held off in WAIT, then delayed read data in CAP.
        ready_gate = 1'b0;
        val_delay = 2;
        push(64'd3);
        push(64'd4);
        start_run(2);
        en_seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (mul_rd_en) en_seen++;
            tick();
        end
        check("ready_low_no_rd_en", en_seen, 0);
        check("ready_low_busy", busy, 1'b1);
        ready_gate = 1'b1;
        tick();
        check("ready_rd_en_one_cycle_later", mul_rd_en, 1'b1);
        tick();
        check("rd_en_drops", mul_rd_en, 1'b0);
        check("cap_wait_no_add_0", acc_data, 64'd0);
        tick();
        check("cap_wait_no_add_1", acc_data, 64'd0);
        tick();
        check("cap_wait_no_add_2", acc_data, 64'd0);
        tick();
        check("cap_add_on_val", acc_data, 64'd3);
        wait_done(1'b0);
        finish_run("delayed", 2, 64'd7, 1'b0);

        // Reset while in CAP of product 2 of 4.
        val_delay = 0;
        push(64'd1); push(64'd2); push(64'd3); push(64'd4);
        start_run(4);
        en_seen = 0;
        for (int k = 0; k < 100 && en_seen < 2; k++) begin
            if (mul_rd_en) en_seen++;
            if (en_seen < 2) tick();
        end
        check("midrun_reach_req2", en_seen, 2);
        tick();
        reset = 1'b1;
        tick();
        check("midrun_rst_mul_rd_en", mul_rd_en, 1'b0);
        check("midrun_rst_acc_data", acc_data, 64'd0);
        check("midrun_rst_acc_val", acc_val, 1'b0);
        check("midrun_rst_overflow", overflow, 1'b0);
        check("midrun_rst_busy", busy, 1'b0);
        reset = 1'b0;
        tick();
        check("midrun_post_rst_rd_en", mul_rd_en, 1'b0);
        push(64'd9);
        start_run(1);
        wait_done(1'b0);
        finish_run("after_reset", 1, 64'd9, 1'b0);

        // Maximum length run.
        total = '0;
        for (int j = 1; j <= 255; j++) begin
            push(PW'(j));
            total += 128'(j);
        end
        start_run(255);
        wait_done(1'b0);
        finish_run("len255", 255, total[AW-1:0], 1'b0);

        // Randomized runs against a plain-arithmetic sum model.
        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(0, 6);
            val_delay = $urandom_range(0, 2);
            total = '0;
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 3) == 0) p = {$urandom, $urandom};
                else p = PW'($urandom_range(0, 1000));
                push(p);
                total += 128'(p);
            end
            exp_o = (total >= (128'd1 << AW));
`ifdef MUL_ACC_SAT_EN
            exp_d = exp_o ? '1 : total[AW-1:0];
`else
            exp_d = total[AW-1:0];
`endif
            start_run(n);
            wait_done(1'b0);
            finish_run($sformatf("rand%0d", r), n, exp_d, exp_o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

endmodule
